// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared types and constants for the DES byte loader
//
// Purpose: FSM state encoding, block geometry and a byte-shift helper used
//          by des_byte_loader and its sub-modules.
// Ports:   none (package).
package des_pkg;

  localparam int BLOCK_W         = 64;
  localparam int BYTES_PER_BLOCK = 8;
  localparam int BCNT_W          = $clog2(BYTES_PER_BLOCK);

  typedef enum logic [1:0] {
    ST_COLLECT   = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_DATA_WAIT = 2'd2,
    ST_KEY_WAIT  = 2'd3
  } state_e;

  // Bytes arrive MSB first, so shifting left by a byte per arrival leaves the
  // first byte in the top lane once the group is complete.
  function automatic logic [BLOCK_W-1:0] shift_in_byte(input logic [BLOCK_W-1:0] cur,
                                                       input logic [7:0]         b);
    return {cur[BLOCK_W-9:0], b};
  endfunction

endpackage

// File: rtl/inflight_counter.sv
// rtl/inflight_counter.sv - saturating up/down occupancy counter with underflow flag
//
// Purpose: counts items issued into a pipeline but not yet returned.
// Ports:
//   clk, rstn   clock and synchronous active-low reset
//   inc         one item entered the pipeline this cycle
//   dec         one item left the pipeline this cycle
//   count       current occupancy
//   underflow   combinational: dec seen with nothing to remove (count held at 0)
module inflight_counter #(
  parameter int MAX_COUNT = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case ({inc, dec})
      2'b10: if (count_q != CNT_W'(MAX_COUNT)) count_d = count_q + CNT_W'(1);
      2'b01: if (count_q != '0)                count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count     = count_q;
  assign underflow = dec & ~inc & (count_q == '0);

endmodule

// File: rtl/des_byte_loader.sv
// rtl/des_byte_loader.sv - byte-serial key/data assembler feeding des_top
//
// Purpose: packs a byte stream into 64-bit key and data groups, issues data
//          blocks to the DES core with a one-cycle valid_in, and holds off key
//          and mode changes until every issued block has come back.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   byte_in          payload byte
//   byte_valid       byte_in valid
//   byte_is_key      group type sideband (1 key, 0 data)
//   mode_in          encrypt(0)/decrypt(1), taken with the 8th key byte
//   byte_ready       loader accepts a byte this cycle
//   core_valid_out   des_top valid_out (one block returned)
//   plain_text       des_top plain_text
//   cipher_key       des_top cipher_key
//   encrypt_decrypt  des_top encrypt_decrypt
//   valid_in         des_top valid_in (one-cycle pulse)
//   key_loaded       a key has been committed since reset
//   inflight         blocks currently inside the core
//   err              one-cycle pulse on group type change or return underflow
module des_byte_loader
  import des_pkg::*;
#(
  parameter int MAX_INFLIGHT = 16,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  input  logic               byte_is_key,
  input  logic               mode_in,
  output logic               byte_ready,
  input  logic               core_valid_out,
  output logic [BLOCK_W-1:0] plain_text,
  output logic [BLOCK_W-1:0] cipher_key,
  output logic               encrypt_decrypt,
  output logic               valid_in,
  output logic               key_loaded,
  output logic [CNT_W-1:0]   inflight,
  output logic               err
);

  state_e              state_q, state_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic                grp_key_q, grp_key_d;
  logic [BLOCK_W-1:0]  stage_q, stage_d;
  logic                mode_stage_q, mode_stage_d;
  logic [BLOCK_W-1:0]  plain_text_q, plain_text_d;
  logic [BLOCK_W-1:0]  cipher_key_q, cipher_key_d;
  logic                enc_dec_q, enc_dec_d;
  logic                key_loaded_q, key_loaded_d;
  logic                err_q, err_d;

  logic [CNT_W-1:0]    inflight_cnt;
  logic                cnt_underflow;
  logic                accept;
  logic                grp_mismatch;
  logic                last_byte;
  logic                below_max;
  logic                issue_ok;
  logic                core_empty;

  inflight_counter #(
    .MAX_COUNT (MAX_INFLIGHT),
    .CNT_W     (CNT_W)
  ) u_inflight (
    .clk       (clk),
    .rstn      (rstn),
    .inc       (valid_in),
    .dec       (core_valid_out),
    .count     (inflight_cnt),
    .underflow (cnt_underflow)
  );

  assign accept       = byte_valid & byte_ready;
  // A type change is only meaningful once a group has started.
  assign grp_mismatch = accept & (byte_cnt_q != '0) & (byte_is_key != grp_key_q);
  assign last_byte    = accept & ~grp_mismatch & (byte_cnt_q == BCNT_W'(BYTES_PER_BLOCK - 1));
  assign below_max    = inflight_cnt < CNT_W'(MAX_INFLIGHT);
  assign issue_ok     = key_loaded_q & below_max;
  assign core_empty   = (inflight_cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_COLLECT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_COLLECT: begin
        if (last_byte) begin
          if (byte_is_key)   state_d = ST_KEY_WAIT;
          else if (issue_ok) state_d = ST_ISSUE;
          else               state_d = ST_DATA_WAIT;
        end
      end
      ST_ISSUE:     state_d = ST_COLLECT;
      ST_DATA_WAIT: if (issue_ok)   state_d = ST_ISSUE;
      ST_KEY_WAIT:  if (core_empty) state_d = ST_COLLECT;
      default:      state_d = ST_COLLECT;
    endcase
  end

  // FSM outputs
  always_comb begin
    byte_ready = (state_q == ST_COLLECT);
    valid_in   = (state_q == ST_ISSUE);
  end

  // Staging, commit and error datapath
  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    grp_key_d    = grp_key_q;
    stage_d      = stage_q;
    mode_stage_d = mode_stage_q;
    plain_text_d = plain_text_q;
    cipher_key_d = cipher_key_q;
    enc_dec_d    = enc_dec_q;
    key_loaded_d = key_loaded_q;
    err_d        = grp_mismatch | cnt_underflow;

    if (accept) begin
      if (grp_mismatch) begin
        // Drop the partial group; this byte opens a new one of its own type.
        stage_d    = {{(BLOCK_W-8){1'b0}}, byte_in};
        byte_cnt_d = BCNT_W'(1);
        grp_key_d  = byte_is_key;
      end else begin
        stage_d    = shift_in_byte(stage_q, byte_in);
        byte_cnt_d = byte_cnt_q + BCNT_W'(1);  // wraps to 0 after the 8th byte
        if (byte_cnt_q == '0) grp_key_d = byte_is_key;
      end
      if (last_byte && byte_is_key) mode_stage_d = mode_in;
    end

    // stage_d already carries the 8th byte when going straight from COLLECT.
    if (state_d == ST_ISSUE) plain_text_d = stage_d;

    if (state_q == ST_KEY_WAIT && core_empty) begin
      cipher_key_d = stage_q;
      enc_dec_d    = mode_stage_q;
      key_loaded_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      byte_cnt_q   <= '0;
      grp_key_q    <= 1'b0;
      stage_q      <= '0;
      mode_stage_q <= 1'b0;
      plain_text_q <= '0;
      cipher_key_q <= '0;
      enc_dec_q    <= 1'b0;
      key_loaded_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      grp_key_q    <= grp_key_d;
      stage_q      <= stage_d;
      mode_stage_q <= mode_stage_d;
      plain_text_q <= plain_text_d;
      cipher_key_q <= cipher_key_d;
      enc_dec_q    <= enc_dec_d;
      key_loaded_q <= key_loaded_d;
      err_q        <= err_d;
    end
  end

  assign plain_text      = plain_text_q;
  assign cipher_key      = cipher_key_q;
  assign encrypt_decrypt = enc_dec_q;
  assign key_loaded      = key_loaded_q;
  assign inflight        = inflight_cnt;
  assign err             = err_q;

endmodule

// File: tb/tb_des_byte_loader.sv
// tb/tb_des_byte_loader.sv - scoreboard bench for des_byte_loader
module tb_des_byte_loader;

  localparam int MAXF = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_is_key;
  logic        mode_in;
  logic        byte_ready;
  logic        core_valid_out;
  logic [63:0] plain_text;
  logic [63:0] cipher_key;
  logic        encrypt_decrypt;
  logic        valid_in;
  logic        key_loaded;
  logic [7:0]  inflight;
  logic        err;

  always #5 clk = ~clk;

  des_byte_loader #(.MAX_INFLIGHT(MAXF), .CNT_W(8)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .byte_in         (byte_in),
    .byte_valid      (byte_valid),
    .byte_is_key     (byte_is_key),
    .mode_in         (mode_in),
    .byte_ready      (byte_ready),
    .core_valid_out  (core_valid_out),
    .plain_text      (plain_text),
    .cipher_key      (cipher_key),
    .encrypt_decrypt (encrypt_decrypt),
    .valid_in        (valid_in),
    .key_loaded      (key_loaded),
    .inflight        (inflight),
    .err             (err)
  );

  typedef struct {
    logic [63:0] pt;
    logic [63:0] key;
    logic        mode;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t e;

  // Reference model of the byte stream
  logic [63:0] m_grp;
  int          m_len;
  logic        m_type;
  logic [63:0] m_key;
  logic        m_mode;
  bit          m_key_loaded;
  int          exp_err = 0;
  int          err_seen = 0;
  int          n_issued = 0;
  int          n_returned = 0;

  // Core stand-in
  int cyc = 0;
  int manual_pulses = 0;
  bit core_auto = 0;
  int due_q[$];
  int last_due = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_accept(input logic [7:0] b, input logic k, input logic m);
    if (m_len > 0 && k != m_type) begin
      exp_err++;
      m_len = 0;
    end
    if (m_len == 0) begin
      m_type = k;
      m_grp  = '0;
    end
    m_grp = {m_grp[55:0], b};
    m_len++;
    if (m_len == 8) begin
      m_len = 0;
      if (k) begin
        m_key = m_grp;
        m_mode = m;
        m_key_loaded = 1;
      end else if (m_key_loaded) begin
        exp_q.push_back('{pt: m_grp, key: m_key, mode: m_mode});
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    due_q.delete();
    last_due = 0;
    m_len = 0;
    m_grp = '0;
    m_type = 0;
    m_key_loaded = 0;
    n_issued = 0;
    n_returned = 0;
  endtask

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input logic k, input logic m);
    int t = 0;
    byte_in = b; byte_is_key = k; mode_in = m; byte_valid = 1;
    while (!byte_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!byte_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: byte %h not accepted within %0d cycles", b, t);
      byte_valid = 0;
      return;
    end
    @(posedge clk); #1;
    byte_valid = 0;
    model_accept(b, k, m);
  endtask

  task automatic send_group(input logic [63:0] v, input logic k, input logic m, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      send_byte(v[63-8*i -: 8], k, m);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rstn = 0; byte_valid = 0; manual_pulses = 0;
    idle(2);
    model_reset();
    chk("rst_plain_text", plain_text, 0);
    chk("rst_cipher_key", cipher_key, 0);
    chk("rst_encrypt_decrypt", encrypt_decrypt, 0);
    chk("rst_valid_in", valid_in, 0);
    chk("rst_key_loaded", key_loaded, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err, 0);
    rstn = 1;
    idle(1);
    chk("ready_after_reset", byte_ready, 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || n_issued != n_returned) && t < 3000) begin
      idle(1);
      t++;
    end
    chk("drain_done", (exp_q.size() == 0 && n_issued == n_returned), 1);
    idle(3);
    chk("drain_inflight", inflight, 0);
  endtask

  // Monitor: pops the scoreboard on every issue and watches key stability.
  logic        prev_valid = 0;
  logic [63:0] key_prev = '0;
  logic        mode_prev = 0;
  logic [7:0]  infl_prev = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_valid = 0;
      infl_prev  = '0;
    end else begin
      if (valid_in) begin
        chk("valid_in_back_to_back", prev_valid, 0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_unexpected: plain_text %h issued with no block expected", plain_text);
        end else begin
          e = exp_q.pop_front();
          chk("issue_plain_text", plain_text, e.pt);
          chk("issue_cipher_key", cipher_key, e.key);
          chk("issue_mode", encrypt_decrypt, e.mode);
        end
        n_issued++;
        if (core_auto) begin
          int d;
          d = cyc + $urandom_range(1, 20);
          if (d <= last_due) d = last_due + 1;
          due_q.push_back(d);
          last_due = d;
        end
      end
      if (infl_prev != 0) begin
        chk("key_stable_inflight", cipher_key, key_prev);
        chk("mode_stable_inflight", encrypt_decrypt, mode_prev);
      end
      if (err) err_seen++;
      prev_valid = valid_in;
      key_prev   = cipher_key;
      mode_prev  = encrypt_decrypt;
      infl_prev  = inflight;
    end
  end

  // Core stand-in: returns blocks either on request or after a random latency.
  initial begin
    core_valid_out = 0;
    forever begin
      @(posedge clk); #1;
      core_valid_out = 0;
      if (!rstn) begin
        due_q.delete();
      end else if (manual_pulses > 0) begin
        core_valid_out = 1;
        manual_pulses--;
        if (n_issued > n_returned) n_returned++;
      end else if (core_auto && due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        core_valid_out = 1;
        n_returned++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] D1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [63:0] K3 = 64'h1122_3344_5566_7788;

  initial begin
    rstn = 0; byte_valid = 0; byte_in = '0; byte_is_key = 0; mode_in = 0;
    idle(1);
    do_reset();

    // Data with no key loaded stalls in DATA_WAIT.
    send_group(64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0);
    idle(20);
    chk("nokey_byte_ready", byte_ready, 0);
    chk("nokey_key_loaded", key_loaded, 0);
    chk("nokey_inflight", inflight, 0);
    do_reset();

    // Known-answer key and data, with latency checks.
    send_group(K1, 1, 0, 0);
    chk("key_wait_ready", byte_ready, 0);
    chk("key_not_yet", cipher_key, 0);
    idle(1);
    chk("key_commit", cipher_key, K1);
    chk("key_mode", encrypt_decrypt, 0);
    chk("key_loaded", key_loaded, 1);
    chk("key_ready_again", byte_ready, 1);
    send_group(D1, 0, 0, 0);
    chk("data_latency_valid", valid_in, 1);
    chk("data_plain_text", plain_text, D1);

    // In-flight limit with the core holding everything.
    send_group({$urandom, $urandom}, 0, 0, 1);
    send_group({$urandom, $urandom}, 0, 0, 1);
    idle(2);
    chk("limit_inflight_full", inflight, MAXF);
    send_group({$urandom, $urandom}, 0, 0, 0);
    idle(6);
    chk("limit_stalled_inflight", inflight, MAXF);
    chk("limit_stalled_ready", byte_ready, 0);
    manual_pulses = 1;
    idle(6);
    chk("limit_after_return", inflight, MAXF);
    chk("limit_ready_again", byte_ready, 1);

    // New key while blocks are in flight.
    send_group(K2, 1, 1, 1);
    idle(10);
    chk("held_key_1", cipher_key, K1);
    chk("held_ready", byte_ready, 0);
    manual_pulses = 2;
    idle(8);
    chk("held_key_2", cipher_key, K1);
    chk("held_inflight", inflight, 1);
    manual_pulses = 1;
    idle(6);
    chk("new_key", cipher_key, K2);
    chk("new_mode", encrypt_decrypt, 1);
    chk("new_key_inflight", inflight, 0);
    chk("no_err_so_far", err_seen, exp_err);

    // Group type flips on the 5th data byte.
    for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), 0, 0);
    send_group(K3, 1, 0, 0);
    idle(3);
    chk("mismatch_err_count", err_seen, exp_err);
    chk("mismatch_key", cipher_key, K3);
    chk("mismatch_mode", encrypt_decrypt, 0);
    send_group({$urandom, $urandom}, 0, 0, 1);
    idle(2);
    manual_pulses = 1;
    idle(4);

    // Return with nothing in flight.
    manual_pulses = 1;
    exp_err++;
    idle(4);
    chk("underflow_err_count", err_seen, exp_err);
    chk("underflow_inflight", inflight, 0);

    // Randomized traffic with a self-returning core.
    core_auto = 1;
    for (int g = 0; g < 30; g++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_group({$urandom, $urandom}, 1, 1'($urandom_range(0, 1)), 1);
      end else if (r == 1) begin
        logic t;
        t = 1'($urandom_range(0, 1));
        for (int i = 0; i < $urandom_range(1, 7); i++) send_byte(8'($urandom), t, 0);
        send_group({$urandom, $urandom}, ~t, 1'($urandom_range(0, 1)), 1);
      end else begin
        send_group({$urandom, $urandom}, 0, 0, 1);
      end
    end
    wait_drain();
    core_auto = 0;

    // Reset in the middle of a data group.
    for (int i = 0; i < 4; i++) send_byte(8'hE0 + 8'(i), 0, 0);
    do_reset();
    send_group(64'h0F1E2D3C4B5A6978, 1, 0, 0);
    idle(1);
    send_group(64'h8899AABBCCDDEEFF, 0, 0, 0);
    chk("post_reset_valid", valid_in, 1);
    chk("post_reset_plain_text", plain_text, 64'h8899AABBCCDDEEFF);
    idle(2);
    manual_pulses = 1;
    idle(5);

    chk("final_scoreboard_empty", exp_q.size(), 0);
    chk("final_err_count", err_seen, exp_err);
    chk("final_inflight", inflight, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
